// File: rtl/addsub_pkg.sv
// =============================================================================
// addsub_pkg : shared digit size, FSM encoding and digit-count helper
// Revision   : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

package addsub_pkg;

  localparam int DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_digits(input int width);
    return width / DIGIT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_digit4.sv
// =============================================================================
// cla_digit4 : combinational 4-bit carry-lookahead digit adder
// Revision   : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_digit4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c4,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products so the digit stays two gate levels deep.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (&p & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

`default_nettype wire

// File: rtl/ser_addsub_cla.sv
// =============================================================================
// ser_addsub_cla : digit-serial add/sub, one 4-bit lookahead digit per cycle
// Revision       : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module ser_addsub_cla
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int            D          = num_digits(WIDTH);
  localparam int            CW         = $clog2(D);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c3_q, c3_d;
  logic             fin_q, fin_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c4;
  logic             dig_c3;

  assign dig_a = a_q[cnt_q*DIGIT +: DIGIT];
  assign dig_b = b_q[cnt_q*DIGIT +: DIGIT];

  cla_digit4 u_digit (
    .a   (dig_a),
    .b   (dig_b),
    .cin (carry_q),
    .s   (dig_s),
    .c4  (dig_c4),
    .c3  (dig_c3)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c3_d    = c3_q;
    fin_d   = fin_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B here and seed the carry with sub.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          fin_d   = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (fin_q) begin
          // Flags come from registered state so the wide zero test stays off the digit path.
          cout_d  = carry_q;
          ovf_d   = carry_q ^ c3_q;
          zero_d  = (sum_q == '0);
          fin_d   = 1'b0;
          state_d = DONE;
        end else begin
          sum_d[cnt_q*DIGIT +: DIGIT] = dig_s;
          carry_d = dig_c4;
          if (cnt_q == LAST_DIGIT) begin
            c3_d  = dig_c3;
            fin_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c3_q    <= 1'b0;
      fin_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c3_q    <= c3_d;
      fin_q   <= fin_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_ser_addsub_cla.sv
// =============================================================================
// tb_ser_addsub_cla : directed and randomized checks for ser_addsub_cla
// Revision          : 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ser_addsub_cla;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  ser_addsub_cla #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Reference: signed integer arithmetic for sum/overflow, unsigned magnitude for carry.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    res_t   r;
    longint sx, sy, full, ux, uy;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ux   = longint'({32'd0, x});
    uy   = longint'({32'd0, y});
    full = s ? (sx - sy) : (sx + sy);
    r.s  = full[31:0];
    r.v  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    r.c  = s ? (x >= y) : ((ux + uy) > 64'sd4294967295);
    r.z  = (r.s == 32'd0);
    return r;
  endfunction

  // Drives one operation; lat = edges from acceptance to done, rlow = sampled cycles with ready low.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        output res_t got, output int lat, output int rlow);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    rlow = ready ? 0 : 1;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (!ready) rlow++;
    end
    got.s = sum; got.c = cout; got.v = ovf; got.z = zero;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ready, done} !== 2'b10) $display("FAIL reset_hs: got ready/done %b exp 10", {ready, done}); else passed++;
    checks++; if (sum !== 32'd0) $display("FAIL reset_sum: got %h exp 00000000", sum); else passed++;
    checks++; if ({cout, ovf, zero} !== 3'b001) $display("FAIL reset_flags: got cov/z %b exp 001", {cout, ovf, zero}); else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) $display("FAIL reset_idle: got ready %b exp 1", ready); else passed++;
  endtask

  task automatic test_directed();
    logic [31:0] va [4] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h80000000};
    logic [31:0] vb [4] = '{32'h00000001, 32'h00000001, 32'h00000007, 32'h00000001};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] es [4] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
    logic [2:0]  ef [4] = '{3'b101, 3'b010, 3'b000, 3'b110};
    res_t got;
    int   lat, rlow;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], got, lat, rlow);
      checks++; if (got.s !== es[i]) $display("FAIL dir%0d_sum: got %h exp %h", i, got.s, es[i]); else passed++;
      checks++; if ({got.c, got.v, got.z} !== ef[i]) $display("FAIL dir%0d_flags: got cov/z %b exp %b", i, {got.c, got.v, got.z}, ef[i]); else passed++;
      checks++; if (lat !== 9) $display("FAIL dir%0d_latency: got %0d edges exp 9", i, lat); else passed++;
      checks++; if (rlow !== 10) $display("FAIL dir%0d_ready_low: got %0d cycles exp 10", i, rlow); else passed++;
      @(posedge clk); #1;
      checks++; if ({ready, done} !== 2'b10) $display("FAIL dir%0d_pulse: got ready/done %b exp 10", i, {ready, done}); else passed++;
    end
  endtask

  task automatic test_ignore_start();
    int n;
    while (!ready) begin @(posedge clk); #1; end
    a = 32'h00000010; b = 32'h00000020; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    a = 32'hFFFFFFFF; b = 32'h00000001; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (!done && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 9) $display("FAIL ign_latency: got %0d edges exp 9", n); else passed++;
    checks++; if (sum !== 32'h00000030) $display("FAIL ign_sum: got %h exp 00000030", sum); else passed++;
    a = 32'h0000000F; b = 32'h000000F0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (ready !== 1'b1) $display("FAIL ign_done_start: got ready %b exp 1", ready); else passed++;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({ready, done} !== 2'b10) $display("FAIL ign_idle: got ready/done %b exp 10", {ready, done}); else passed++;
    checks++; if ({sum, cout, ovf, zero} !== {32'h00000030, 3'b000}) $display("FAIL ign_hold: got %h/%b exp 00000030/000", sum, {cout, ovf, zero}); else passed++;
  endtask

  task automatic test_reset_midrun();
    res_t got;
    int   lat, rlow;
    while (!ready) begin @(posedge clk); #1; end
    a = 32'h12345678; b = 32'h11111111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({ready, done} !== 2'b10) $display("FAIL abort_hs: got ready/done %b exp 10", {ready, done}); else passed++;
    checks++; if ({sum, cout, ovf, zero} !== {32'd0, 3'b001}) $display("FAIL abort_out: got %h/%b exp 00000000/001", sum, {cout, ovf, zero}); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(32'h12345678, 32'h11111111, 1'b0, got, lat, rlow);
    checks++; if (got.s !== 32'h23456789) $display("FAIL rerun_sum: got %h exp 23456789", got.s); else passed++;
    checks++; if ({got.c, got.v, got.z} !== 3'b000) $display("FAIL rerun_flags: got %b exp 000", {got.c, got.v, got.z}); else passed++;
    checks++; if (lat !== 9) $display("FAIL rerun_latency: got %0d exp 9", lat); else passed++;
  endtask

  task automatic test_random();
    res_t        got, exp;
    int          lat, rlow;
    logic [31:0] x, y;
    logic        s;
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: y = x;
        1: y = ~x;
        2: x = {1'b1, 31'($urandom_range(0, 15))};
        default: ;
      endcase
      exp = model(x, y, s);
      run_op(x, y, s, got, lat, rlow);
      checks++; if (got.s !== exp.s) $display("FAIL rnd%0d_sum: %h %s %h got %h exp %h", i, x, s ? "-" : "+", y, got.s, exp.s); else passed++;
      checks++; if (got.c !== exp.c) $display("FAIL rnd%0d_cout: got %b exp %b", i, got.c, exp.c); else passed++;
      checks++; if (got.v !== exp.v) $display("FAIL rnd%0d_ovf: got %b exp %b", i, got.v, exp.v); else passed++;
      checks++; if (got.z !== exp.z) $display("FAIL rnd%0d_zero: got %b exp %b", i, got.z, exp.z); else passed++;
      checks++; if (lat !== 9) $display("FAIL rnd%0d_latency: got %0d exp 9", i, lat); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
